spi_regfile_periph: RTL and testbench
=====================================

Name: spi_regfile_periph

Overview:
- SPI mode-0 peripheral (CPOL=0, CPHA=0) giving an external controller read/write access to a parametrised bank of DATA_W-bit control registers.
- Sits between the ui_in SPI pins and the output-enable / PWM control logic.
- All SPI pins are oversampled in the system clock domain; SPI signals are not used as clocks.
- Adds readback on CIPO, address-range checking, abort on early nCS release, and a per-write strobe.

Parameters:
- NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1).
- DATA_W, 8, register width and data-phase bit count.
- ADDR_W, 7, address field width.
- SYNC_STAGES, 2, synchroniser depth on ncs/copi/sclk (minimum 2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ncs  in  1  SPI chip select, active low.
- copi  in  1  controller-out data.
- sclk  in  1  SPI clock; frequency ≤ clk/8.
- cipo  out  1  peripheral-out data.
- cipo_oe  out  1  high while ncs is asserted (synchronised); drives the pad enable.
- regs_flat  out  NUM_REGS*DATA_W  register bank; reg i occupies bits [i*DATA_W +: DATA_W].
- wr_strobe  out  1  one-clk pulse on every committed write.
- wr_addr  out  ADDR_W  address of the last committed write.

Behaviour:
- Reset (async, rst_n=0): all of the following go to 0 — regs_flat, cipo, cipo_oe, wr_strobe, wr_addr, shift registers, bit counter. Synchroniser flops reset to idle levels: ncs=1, sclk=0, copi=0. State = IDLE.
- Reset asserted mid-frame discards the frame. No partial write.
- Frame format, MSB first: 1 R/W bit (1=write, 0=read), then ADDR_W address bits, then DATA_W data bits. Default frame length is 16 bits.
- Sampling: copi sampled on the synchronised sclk rising edge. cipo updated on the synchronised sclk falling edge.
- Edge detect compares the last two synchroniser stages. Latency from a pin edge to its internal event is SYNC_STAGES+1 clk.
- States:
  - IDLE: wait for synchronised ncs falling edge → CMD; clear bit counter.
  - CMD: first rising edge latches R/W → ADDR.
  - ADDR: shift in ADDR_W bits. On the last one:
    - If read: load the read shadow with reg[addr], or 0 if addr ≥ NUM_REGS.
    - Go to DATA.
  - DATA:
    - Write: shift in DATA_W bits.
    - Read: on each falling edge, cipo ← shadow MSB, then shift the shadow left. The first falling edge after the last address bit presents bit DATA_W-1.
    - After DATA_W rising edges → COMMIT.
  - COMMIT (1 clk):
    - Write with addr < NUM_REGS: reg[addr] ← data, wr_strobe=1, wr_addr=addr.
    - Out-of-range write: dropped, no strobe.
    - Read: nothing to commit.
    - Then → WAIT_CS.
  - WAIT_CS: further sclk edges are ignored. ncs rising edge → IDLE.
- Abort: a synchronised ncs rising edge in CMD/ADDR/DATA → IDLE with no register change and no strobe.
- ncs rising edge and the COMMIT cycle coinciding: the commit takes effect.
- cipo is held at 0 outside the DATA phase of reads.
- Bit counter is $clog2(ADDR_W+DATA_W+1) wide and saturates; it never wraps within a frame.
- Registers are never modified by reads.

Optional Feature:
- SPI_BURST_EN defined:
  - After COMMIT, the block returns to DATA instead of WAIT_CS, with address+1.
  - Each further DATA_W bits commits or reads the next register.
  - Address does not wrap: past NUM_REGS-1, writes are dropped and reads return 0.
- Undefined: the single-transfer behaviour described above.

Decomposition:
- Package spi_regfile_pkg holds:
  - state enum (IDLE, CMD, ADDR, DATA, COMMIT, WAIT_CS);
  - localparams for the R/W encoding (WRITE=1'b1);
  - frame-length helper constant.
- Sub-module spi_sync_edge (parameter SYNC_STAGES, reset value): one-bit synchroniser plus rise/fall pulse outputs. Instantiated three times.

Test Plan:
- Write frame 1,0000010,0xA5 → regs_flat[23:16]=0xA5; wr_strobe high exactly 1 clk; wr_addr=2; other registers unchanged.
- After that write, read frame 0,0000010 → cipo bits 1,0,1,0,0,1,0,1 sampled on the 8 data rising edges; reg[2] is still 0xA5.
- Write 0x3C to addr 1, with ncs released after 10 bits → reg[1] stays 0; no wr_strobe; the next full frame succeeds.
- NUM_REGS=5: write 0xFF to addr 7 → no register changes, no strobe. Read addr 7 → cipo all 0.
- rst_n pulsed low during the data phase of a write to addr 0 → all outputs 0 immediately. The following frame writing 0x81 to addr 0 → reg[0]=0x81.
- SPI_BURST_EN: write addr 3, data 0x11,0x22,0x33 in one ncs frame → reg[3]=0x11, reg[4]=0x22; third byte dropped; two wr_strobe pulses with wr_addr 3 then 4.

Source files
------------

// File: rtl/spi_regfile_pkg.sv
// Shared types and constants for the SPI register-file peripheral.
package spi_regfile_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    COMMIT,
    WAIT_CS
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

  function automatic int unsigned frame_len(input int unsigned addr_w, input int unsigned data_w);
    return 1 + addr_w + data_w;
  endfunction

  localparam int unsigned FRAME_LEN_DEFAULT = frame_len(7, 8);

endpackage

// File: rtl/spi_sync_edge.sv
// One-bit synchroniser with rising/falling edge pulses taken from the last
// synchroniser stage and its delayed copy.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic        RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  // [SYNC_STAGES-1:0] is the synchroniser chain, [SYNC_STAGES] the previous value
  logic [SYNC_STAGES:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= {(SYNC_STAGES + 1){RST_VAL}};
    else        r_sync <= {r_sync[SYNC_STAGES-1:0], i_pin};
  end

  assign o_level = r_sync[SYNC_STAGES-1];
  assign o_rise  = r_sync[SYNC_STAGES-1] & ~r_sync[SYNC_STAGES];
  assign o_fall  = ~r_sync[SYNC_STAGES-1] & r_sync[SYNC_STAGES];

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI mode-0 peripheral giving read/write access to a bank of control registers.
// Define SPI_BURST_EN to continue into address+1 after each commit within one nCS frame.
module spi_regfile_periph
  import spi_regfile_pkg::*;
#(
  parameter int unsigned NUM_REGS    = 5,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ncs,
  input  logic                         copi,
  input  logic                         sclk,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr
);

  localparam int unsigned FRAME_LEN = frame_len(ADDR_W, DATA_W);
  localparam int unsigned CNT_W     = $clog2(ADDR_W + DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(ADDR_W - 1);
  localparam logic [CNT_W-1:0] CNT_DATA_LAST = CNT_W'(FRAME_LEN - 2);

  logic w_ncs_lvl, w_ncs_rise, w_ncs_fall;
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_copi, w_copi_rise, w_copi_fall;
  logic w_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .i_pin(ncs),
    .o_level(w_ncs_lvl), .o_rise(w_ncs_rise), .o_fall(w_ncs_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .i_pin(sclk),
    .o_level(w_sclk_lvl), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
  );
  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .i_pin(copi),
    .o_level(w_copi), .o_rise(w_copi_rise), .o_fall(w_copi_fall)
  );

  assign w_unused = &{1'b0, w_sclk_lvl, w_copi_rise, w_copi_fall};

  state_t              r_state, w_state_nxt;
  logic                r_rw;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [DATA_W-1:0]   r_shadow;
  logic [CNT_W-1:0]    r_bitcnt;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic                r_cipo;
  logic                r_wr_strobe;
  logic [ADDR_W-1:0]   r_wr_addr;

  logic [ADDR_W-1:0]   w_addr_next;
  logic [ADDR_W-1:0]   w_rd_sel;
  logic [DATA_W-1:0]   w_rd_val;
  logic [CNT_W-1:0]    w_cnt_inc;
  logic                w_commit_wr;
  logic                w_addr_last;
  logic                w_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_ncs_fall) w_state_nxt = CMD;
      CMD:     if (w_ncs_rise) w_state_nxt = IDLE;
               else if (w_sclk_rise) w_state_nxt = ADDR;
      ADDR:    if (w_ncs_rise) w_state_nxt = IDLE;
               else if (w_sclk_rise && r_bitcnt == CNT_ADDR_LAST) w_state_nxt = DATA;
      DATA:    if (w_ncs_rise) w_state_nxt = IDLE;
               else if (w_sclk_rise && r_bitcnt == CNT_DATA_LAST) w_state_nxt = COMMIT;
      // ncs release coinciding with COMMIT: commit still happens, release is not lost
      COMMIT:  if (w_ncs_rise) w_state_nxt = IDLE;
`ifdef SPI_BURST_EN
               else w_state_nxt = DATA;
`else
               else w_state_nxt = WAIT_CS;
`endif
      WAIT_CS: if (w_ncs_rise) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_addr_next = {r_addr[ADDR_W-2:0], w_copi};
    w_cnt_inc   = (r_bitcnt == '1) ? r_bitcnt : r_bitcnt + CNT_W'(1);
    w_commit_wr = (r_state == COMMIT) && (r_rw == RW_WRITE) && (32'(r_addr) < NUM_REGS);
    w_addr_last = (r_state == ADDR) && w_sclk_rise && (r_bitcnt == CNT_ADDR_LAST);
    w_rd_data   = (r_state == DATA) && (r_rw == RW_READ);
`ifdef SPI_BURST_EN
    w_rd_sel    = (r_state == COMMIT) ? ((r_addr == '1) ? r_addr : r_addr + ADDR_W'(1))
                                      : w_addr_next;
`else
    w_rd_sel    = w_addr_next;
`endif
    w_rd_val    = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++)
      if (w_rd_sel == ADDR_W'(i)) w_rd_val = r_regs[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_shadow    <= '0;
      r_bitcnt    <= '0;
      r_cipo      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_wr_strobe <= w_commit_wr;
      if (w_commit_wr) r_wr_addr <= r_addr;
      for (int unsigned i = 0; i < NUM_REGS; i++)
        if (w_commit_wr && r_addr == ADDR_W'(i)) r_regs[i] <= r_wdata;

      if (!w_rd_data)       r_cipo <= 1'b0;
      else if (w_sclk_fall) r_cipo <= r_shadow[DATA_W-1];

      case (r_state)
        IDLE: r_bitcnt <= '0;
        CMD:  if (w_sclk_rise) r_rw <= w_copi;
        ADDR: if (w_sclk_rise) begin
          r_addr   <= w_addr_next;
          r_bitcnt <= w_cnt_inc;
          if (w_addr_last && r_rw == RW_READ) r_shadow <= w_rd_val;
        end
        DATA: begin
          if (w_sclk_rise) begin
            r_bitcnt <= w_cnt_inc;
            if (r_rw == RW_WRITE) r_wdata <= {r_wdata[DATA_W-2:0], w_copi};
          end
          if (w_sclk_fall && r_rw == RW_READ) r_shadow <= {r_shadow[DATA_W-2:0], 1'b0};
        end
`ifdef SPI_BURST_EN
        // next word restarts the data-phase count; address saturates instead of wrapping
        COMMIT: begin
          r_bitcnt <= CNT_W'(ADDR_W);
          r_addr   <= w_rd_sel;
          if (r_rw == RW_READ) r_shadow <= w_rd_val;
        end
`endif
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = r_regs[g];
  end

  assign cipo      = r_cipo;
  assign cipo_oe   = ~w_ncs_lvl;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;

endmodule

// File: tb/tb_spi_regfile_periph.sv
// Scoreboard bench for spi_regfile_periph: write strobes and read data are
// compared against expectations queued when each frame is driven.
module tb_spi_regfile_periph;

  localparam int NUM_REGS = 5;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ncs = 1'b1;
  logic copi = 1'b0;
  logic sclk = 1'b0;
  logic cipo, cipo_oe, wr_strobe;
  logic [NUM_REGS*DATA_W-1:0] regs_flat;
  logic [ADDR_W-1:0] wr_addr;

  spi_regfile_periph #(.NUM_REGS(NUM_REGS), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .copi(copi), .sclk(sclk),
    .cipo(cipo), .cipo_oe(cipo_oe), .regs_flat(regs_flat),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_exp_t;

  wr_exp_t    exp_wr[$];
  logic [7:0] exp_rd[$];
  logic [7:0] model [NUM_REGS];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [NUM_REGS*DATA_W-1:0] model_flat();
    logic [NUM_REGS*DATA_W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model[i];
    return f;
  endfunction

  // every strobe cycle must match the oldest queued write
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_strobe", {63'd0, wr_strobe}, 64'd0);
      end else begin
        wr_exp_t e;
        e = exp_wr.pop_front();
        check("wr_addr", {57'd0, wr_addr}, 64'(e.addr));
        check("wr_data", {56'd0, regs_flat[e.addr*DATA_W +: DATA_W]}, {56'd0, e.data});
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_xfer(input logic [31:0] bits, input int nbits, input bit release_cs,
                          output logic [31:0] rd_bits, output logic oe_seen);
    rd_bits = '0;
    oe_seen = 1'b0;
    ncs = 1'b0;
    wait_clk(8);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = bits[i];
      wait_clk(8);
      sclk = 1'b1;
      rd_bits = {rd_bits[30:0], cipo};
      oe_seen = oe_seen | cipo_oe;
      wait_clk(8);
      sclk = 1'b0;
    end
    wait_clk(8);
    if (release_cs) begin
      ncs = 1'b1;
      wait_clk(12);
    end
  endtask

  task automatic do_write(input int addr, input logic [7:0] data);
    logic [31:0] rd;
    logic oe;
    if (addr < NUM_REGS) begin
      exp_wr.push_back('{addr, data});
      model[addr] = data;
    end
    spi_xfer({16'd0, 1'b1, 7'(addr), data}, 16, 1'b1, rd, oe);
    check("oe_in_frame", {63'd0, oe}, 64'd1);
    check("strobe_pending", 64'(exp_wr.size()), 64'd0);
    check("regs_after_wr", {24'd0, regs_flat}, {24'd0, model_flat()});
  endtask

  task automatic do_read(input int addr);
    logic [31:0] rd;
    logic oe;
    logic [7:0] e;
    exp_rd.push_back((addr < NUM_REGS) ? model[addr] : 8'h00);
    spi_xfer({16'd0, 1'b0, 7'(addr), 8'h00}, 16, 1'b1, rd, oe);
    e = exp_rd.pop_front();
    check("rd_data", {56'd0, rd[7:0]}, {56'd0, e});
    check("regs_after_rd", {24'd0, regs_flat}, {24'd0, model_flat()});
  endtask

  initial begin
    logic [31:0] rd;
    logic oe;
    logic [15:0] fr;
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;

    wait_clk(3);
    check("rst_regs", {24'd0, regs_flat}, 64'd0);
    check("rst_cipo", {63'd0, cipo}, 64'd0);
    check("rst_oe", {63'd0, cipo_oe}, 64'd0);
    check("rst_strobe", {63'd0, wr_strobe}, 64'd0);
    check("rst_wr_addr", {57'd0, wr_addr}, 64'd0);
    rst_n = 1'b1;
    wait_clk(4);

    do_write(2, 8'hA5);
    do_read(2);

    // write to addr 1 abandoned after 10 bits
    fr = {1'b1, 7'd1, 8'h3C};
    spi_xfer({16'd0, fr} >> 6, 10, 1'b1, rd, oe);
    check("abort_regs", {24'd0, regs_flat}, {24'd0, model_flat()});
    check("abort_oe_idle", {63'd0, cipo_oe}, 64'd0);
    do_write(1, 8'h3C);
    do_read(1);

    do_write(7, 8'hFF);
    do_read(7);

    // reset during the data phase of a write to addr 0
    fr = {1'b1, 7'd0, 8'h81};
    spi_xfer({16'd0, fr} >> 4, 12, 1'b0, rd, oe);
    rst_n = 1'b0;
    #1;
    check("midrst_regs", {24'd0, regs_flat}, 64'd0);
    check("midrst_strobe", {63'd0, wr_strobe}, 64'd0);
    check("midrst_wr_addr", {57'd0, wr_addr}, 64'd0);
    check("midrst_cipo", {63'd0, cipo}, 64'd0);
    check("midrst_oe", {63'd0, cipo_oe}, 64'd0);
    for (int i = 0; i < NUM_REGS; i++) model[i] = 8'h00;
    ncs = 1'b1;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(6);
    do_write(0, 8'h81);
    do_read(0);

    // three data bytes in one frame starting at addr 3
    exp_wr.push_back('{3, 8'h11});
    model[3] = 8'h11;
`ifdef SPI_BURST_EN
    exp_wr.push_back('{4, 8'h22});
    model[4] = 8'h22;
`endif
    spi_xfer({1'b1, 7'd3, 8'h11, 8'h22, 8'h33}, 32, 1'b1, rd, oe);
    check("multi_strobe_pending", 64'(exp_wr.size()), 64'd0);
    check("multi_regs", {24'd0, regs_flat}, {24'd0, model_flat()});
    do_read(3);
    do_read(4);

    wait_clk(10);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
